// File: rtl/audio_sequencer.sv
// Sample-rate sequencer: ticks an ADC conversion, hands the sample to a
// processor, then loads the result into the DAC, with frame timeout and overrun tracking.
module audio_sequencer #(
  parameter int DIV     = 4999,
  parameter int TIMEOUT = 1023
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear_err,
  input  logic       adc_valid,
  input  logic [9:0] adc_data,
  input  logic       proc_done,
  input  logic [9:0] proc_result,
  output logic       adc_start,
  output logic       proc_start,
  output logic [9:0] proc_data,
  output logic       dac_load,
  output logic [9:0] dac_data,
  output logic       busy,
  output logic       err_timeout,
  output logic [7:0] overrun_cnt
);

  localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DIV);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, CONV, PROC} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    proc_data_q, proc_data_d;
  logic [9:0]    dac_data_q, dac_data_d;
  logic          adc_start_q, adc_start_d;
  logic          proc_start_q, proc_start_d;
  logic          dac_load_q, dac_load_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [7:0]    ovr_q, ovr_d;

  logic          tick;
  logic          expired;
  logic          timeout_ev;
  logic [TW-1:0] timer_inc;

  // The cycle with timer_q == TIMEOUT-1 is the last one a frame may spend
  // in CONV+PROC; a strobe there still wins, otherwise the frame aborts.
  assign expired   = (timer_q >= T_LAST);
  assign timer_inc = expired ? timer_q : timer_q + 1'b1;
  assign tick      = enable && (cnt_q == CNT_TOP);

  always_comb begin
    cnt_d        = cnt_q;
    state_d      = state_q;
    timer_d      = timer_q;
    proc_data_d  = proc_data_q;
    dac_data_d   = dac_data_q;
    adc_start_d  = 1'b0;
    proc_start_d = 1'b0;
    dac_load_d   = 1'b0;
    timeout_ev   = 1'b0;

    if (!enable)   cnt_d = '0;
    else if (tick) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d     = START;
          adc_start_d = 1'b1;
          timer_d     = '0;
        end
      end
      START: state_d = CONV;
      CONV: begin
        if (adc_valid) begin
          proc_data_d  = adc_data;
          proc_start_d = 1'b1;
          state_d      = PROC;
          timer_d      = timer_inc;
        end else if (expired) begin
          timeout_ev = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      PROC: begin
        if (proc_done) begin
          dac_data_d = proc_result;
          dac_load_d = 1'b1;
          state_d    = IDLE;
          timer_d    = timer_inc;
        end else if (expired) begin
          timeout_ev = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    // A fresh event in the same cycle as clear_err survives the clear.
    err_d = clear_err ? 1'b0 : err_q;
    if (timeout_ev) err_d = 1'b1;
    ovr_d = clear_err ? 8'd0 : ovr_q;
    if (tick && (state_q != IDLE) && (ovr_d != 8'hFF)) ovr_d = ovr_d + 8'd1;
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      proc_data_q  <= '0;
      dac_data_q   <= '0;
      adc_start_q  <= 1'b0;
      proc_start_q <= 1'b0;
      dac_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      proc_data_q  <= proc_data_d;
      dac_data_q   <= dac_data_d;
      adc_start_q  <= adc_start_d;
      proc_start_q <= proc_start_d;
      dac_load_q   <= dac_load_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      ovr_q        <= ovr_d;
    end
  end

  assign adc_start   = adc_start_q;
  assign proc_start  = proc_start_q;
  assign proc_data   = proc_data_q;
  assign dac_load    = dac_load_q;
  assign dac_data    = dac_data_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_audio_sequencer.sv
// Directed bench for audio_sequencer with DIV=9, TIMEOUT=15; inputs driven
// and outputs sampled on the falling edge.
module tb_audio_sequencer;

  logic       sysclk;
  logic       rst_n;
  logic       enable;
  logic       clear_err;
  logic       adc_valid;
  logic [9:0] adc_data;
  logic       proc_done;
  logic [9:0] proc_result;
  logic       adc_start;
  logic       proc_start;
  logic [9:0] proc_data;
  logic       dac_load;
  logic [9:0] dac_data;
  logic       busy;
  logic       err_timeout;
  logic [7:0] overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  audio_sequencer #(.DIV(9), .TIMEOUT(15)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clear_err   (clear_err),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .proc_done   (proc_done),
    .proc_result (proc_result),
    .adc_start   (adc_start),
    .proc_start  (proc_start),
    .proc_data   (proc_data),
    .dac_load    (dac_load),
    .dac_data    (dac_data),
    .busy        (busy),
    .err_timeout (err_timeout),
    .overrun_cnt (overrun_cnt)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Returns the number of falling edges until adc_start is seen, or -1.
  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge sysclk);
      if (adc_start === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Called on the edge adc_start is seen; returns on the edge dac_load should be high.
  task automatic frame(input logic [9:0] a, input logic [9:0] r);
    repeat (3) @(negedge sysclk);
    adc_valid = 1'b1; adc_data = a;
    @(negedge sysclk);
    adc_valid = 1'b0; adc_data = '0;
    @(negedge sysclk);
    proc_done = 1'b1; proc_result = r;
    @(negedge sysclk);
    proc_done = 1'b0; proc_result = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    n_checks++; if (adc_start !== 1'b0) begin n_fail++; $display("FAIL reset_adc_start: got %0b expected 0", adc_start); end
    n_checks++; if (proc_start !== 1'b0) begin n_fail++; $display("FAIL reset_proc_start: got %0b expected 0", proc_start); end
    n_checks++; if (dac_load !== 1'b0) begin n_fail++; $display("FAIL reset_dac_load: got %0b expected 0", dac_load); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", err_timeout); end
    n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt); end
    n_checks++; if (proc_data !== 10'd0) begin n_fail++; $display("FAIL reset_proc_data: got %h expected 000", proc_data); end
    n_checks++; if (dac_data !== 10'd0) begin n_fail++; $display("FAIL reset_dac_data: got %h expected 000", dac_data); end
    rst_n = 1'b1;
    @(negedge sysclk);
  endtask

  task automatic test_normal();
    int c;
    int k;
    enable = 1'b1;
    wait_start(c);
    n_checks++; if (c != 10) begin n_fail++; $display("FAIL first_start_latency: got %0d expected 10", c); end
    @(negedge sysclk);
    n_checks++; if (adc_start !== 1'b0) begin n_fail++; $display("FAIL adc_start_width: got %0b expected 0", adc_start); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %0b expected 1", busy); end
    repeat (2) @(negedge sysclk);
    adc_valid = 1'b1; adc_data = 10'h2A5;
    @(negedge sysclk);
    adc_valid = 1'b0; adc_data = '0;
    n_checks++; if (proc_start !== 1'b1) begin n_fail++; $display("FAIL proc_start_pulse: got %0b expected 1", proc_start); end
    n_checks++; if (proc_data !== 10'h2A5) begin n_fail++; $display("FAIL proc_data_latch: got %h expected 2a5", proc_data); end
    @(negedge sysclk);
    n_checks++; if (proc_start !== 1'b0) begin n_fail++; $display("FAIL proc_start_width: got %0b expected 0", proc_start); end
    @(negedge sysclk);
    proc_done = 1'b1; proc_result = 10'h15A;
    @(negedge sysclk);
    proc_done = 1'b0; proc_result = '0;
    n_checks++; if (dac_load !== 1'b1) begin n_fail++; $display("FAIL dac_load_pulse: got %0b expected 1", dac_load); end
    n_checks++; if (dac_data !== 10'h15A) begin n_fail++; $display("FAIL dac_data_latch: got %h expected 15a", dac_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_frame: got %0b expected 0", busy); end
    @(negedge sysclk);
    n_checks++; if (dac_load !== 1'b0) begin n_fail++; $display("FAIL dac_load_width: got %0b expected 0", dac_load); end
    n_checks++; if (dac_data !== 10'h15A || proc_data !== 10'h2A5) begin n_fail++; $display("FAIL data_hold: got dac %h proc %h expected 15a 2a5", dac_data, proc_data); end
    wait_start(c);
    n_checks++; if (c != 2) begin n_fail++; $display("FAIL sample_period: got %0d edges after load expected 2 (period 10)", c); end
    // Dropping enable mid-frame must still let this frame finish.
    enable = 1'b0;
    frame(10'h111, 10'h222);
    n_checks++; if (dac_load !== 1'b1 || dac_data !== 10'h222) begin n_fail++; $display("FAIL frame_after_disable: got load %0b data %h expected 1 222", dac_load, dac_data); end
    n_checks++; if (proc_data !== 10'h111) begin n_fail++; $display("FAIL proc_data_second: got %h expected 111", proc_data); end
    k = 0;
    repeat (30) begin
      @(negedge sysclk);
      if (adc_start === 1'b1) k++;
    end
    n_checks++; if (k != 0) begin n_fail++; $display("FAIL no_start_when_disabled: got %0d starts expected 0", k); end
    n_checks++; if (err_timeout !== 1'b0 || overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL normal_no_errors: got err %0b ovr %0d expected 0 0", err_timeout, overrun_cnt); end
  endtask

  task automatic test_adc_timeout();
    int c;
    int loads;
    enable = 1'b1;
    wait_start(c);
    n_checks++; if (c != 10) begin n_fail++; $display("FAIL timeout_start_latency: got %0d expected 10", c); end
    enable = 1'b0;
    loads = 0;
    repeat (15) begin
      @(negedge sysclk);
      if (dac_load === 1'b1 || proc_start === 1'b1) loads++;
    end
    n_checks++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_not_early: got busy %0b err %0b expected 1 0", busy, err_timeout); end
    @(negedge sysclk);
    if (dac_load === 1'b1) loads++;
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %0b expected 1", err_timeout); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy %0b expected 0", busy); end
    n_checks++; if (dac_data !== 10'h222) begin n_fail++; $display("FAIL timeout_dac_hold: got %h expected 222", dac_data); end
    n_checks++; if (loads != 0) begin n_fail++; $display("FAIL timeout_no_load: got %0d pulses expected 0", loads); end
    clear_err = 1'b1;
    @(negedge sysclk);
    clear_err = 1'b0;
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL clear_err_flag: got %0b expected 0", err_timeout); end
  endtask

  task automatic test_overrun();
    int c;
    enable = 1'b1;
    wait_start(c);
    repeat (3) @(negedge sysclk);
    adc_valid = 1'b1; adc_data = 10'h0F0;
    @(negedge sysclk);
    adc_valid = 1'b0; adc_data = '0;
    repeat (5) @(negedge sysclk);
    n_checks++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL overrun_before_tick: got %0d expected 0", overrun_cnt); end
    @(negedge sysclk);
    n_checks++; if (overrun_cnt !== 8'd1) begin n_fail++; $display("FAIL overrun_count: got %0d expected 1", overrun_cnt); end
    n_checks++; if (busy !== 1'b1 || adc_start !== 1'b0) begin n_fail++; $display("FAIL overrun_tick_dropped: got busy %0b start %0b expected 1 0", busy, adc_start); end
    @(negedge sysclk);
    enable = 1'b0;
    repeat (3) @(negedge sysclk);
    proc_done = 1'b1; proc_result = 10'h00F;
    @(negedge sysclk);
    proc_done = 1'b0; proc_result = '0;
    n_checks++; if (dac_load !== 1'b1 || dac_data !== 10'h00F) begin n_fail++; $display("FAIL overrun_frame_done: got load %0b data %h expected 1 00f", dac_load, dac_data); end
    n_checks++; if (err_timeout !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL overrun_frame_clean: got err %0b busy %0b expected 0 0", err_timeout, busy); end
  endtask

  task automatic test_coincidence();
    int c;
    enable = 1'b1;
    wait_start(c);
    enable = 1'b0;
    repeat (3) @(negedge sysclk);
    adc_valid = 1'b1; adc_data = 10'h3C3;
    @(negedge sysclk);
    adc_valid = 1'b0; adc_data = '0;
    repeat (11) @(negedge sysclk);
    // Last permitted cycle of the frame: the strobe must beat the timeout.
    proc_done = 1'b1; proc_result = 10'h0C3;
    @(negedge sysclk);
    proc_done = 1'b0; proc_result = '0;
    n_checks++; if (dac_load !== 1'b1 || dac_data !== 10'h0C3) begin n_fail++; $display("FAIL coincide_load: got load %0b data %h expected 1 0c3", dac_load, dac_data); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL coincide_err: got %0b expected 0", err_timeout); end
  endtask

  task automatic test_reset_mid_frame();
    int c;
    enable = 1'b1;
    wait_start(c);
    repeat (3) @(negedge sysclk);
    adc_valid = 1'b1; adc_data = 10'h2AA;
    @(negedge sysclk);
    adc_valid = 1'b0; adc_data = '0;
    repeat (2) @(negedge sysclk);
    rst_n = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0 || dac_load !== 1'b0 || proc_start !== 1'b0 || adc_start !== 1'b0) begin n_fail++; $display("FAIL midreset_pulses: got busy %0b load %0b ps %0b as %0b expected 0 0 0 0", busy, dac_load, proc_start, adc_start); end
    n_checks++; if (proc_data !== 10'd0 || dac_data !== 10'd0) begin n_fail++; $display("FAIL midreset_data: got proc %h dac %h expected 000 000", proc_data, dac_data); end
    n_checks++; if (overrun_cnt !== 8'd0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL midreset_status: got ovr %0d err %0b expected 0 0", overrun_cnt, err_timeout); end
    @(negedge sysclk);
    adc_valid = 1'b1; adc_data = 10'h3FF; proc_done = 1'b1; proc_result = 10'h3FF;
    @(negedge sysclk);
    adc_valid = 1'b0; adc_data = '0; proc_done = 1'b0; proc_result = '0;
    n_checks++; if (proc_start !== 1'b0 || dac_load !== 1'b0 || proc_data !== 10'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_strobes_ignored: got ps %0b load %0b proc %h busy %0b expected 0 0 000 0", proc_start, dac_load, proc_data, busy); end
    wait_start(c);
    n_checks++; if (c != 8) begin n_fail++; $display("FAIL start_after_reset: got %0d expected 8", c); end
    enable = 1'b0;
    frame(10'h2AA, 10'h1B1);
    n_checks++; if (dac_load !== 1'b1 || dac_data !== 10'h1B1) begin n_fail++; $display("FAIL resume_frame: got load %0b data %h expected 1 1b1", dac_load, dac_data); end
  endtask

  task automatic test_saturation_clear();
    // Timed-out frames last 16 cycles, so every other tick (each 20 cycles) is dropped.
    enable = 1'b1;
    repeat (2005) @(negedge sysclk);
    n_checks++; if (overrun_cnt !== 8'd100) begin n_fail++; $display("FAIL overrun_counting: got %0d expected 100", overrun_cnt); end
    repeat (4095) @(negedge sysclk);
    n_checks++; if (overrun_cnt !== 8'd255) begin n_fail++; $display("FAIL overrun_saturate: got %0d expected 255", overrun_cnt); end
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL saturate_err: got %0b expected 1", err_timeout); end
    repeat (19) @(negedge sysclk);
    clear_err = 1'b1;
    @(negedge sysclk);
    clear_err = 1'b0;
    n_checks++; if (overrun_cnt !== 8'd1) begin n_fail++; $display("FAIL clear_vs_overrun: got %0d expected 1", overrun_cnt); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL clear_err_coincide: got %0b expected 0", err_timeout); end
    enable = 1'b0;
    repeat (30) @(negedge sysclk);
    n_checks++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL last_frame_timeout: got err %0b busy %0b expected 1 0", err_timeout, busy); end
    clear_err = 1'b1;
    @(negedge sysclk);
    clear_err = 1'b0;
    n_checks++; if (overrun_cnt !== 8'd0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL clear_all: got ovr %0d err %0b expected 0 0", overrun_cnt, err_timeout); end
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    clear_err   = 1'b0;
    adc_valid   = 1'b0;
    adc_data    = '0;
    proc_done   = 1'b0;
    proc_result = '0;
    @(negedge sysclk);
    test_reset();
    test_normal();
    test_adc_timeout();
    test_overrun();
    test_coincidence();
    test_reset_mid_frame();
    test_saturation_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
